// File: rtl/fpadd_pkg.sv
// Shared constants and types for the fpadd round-robin scheduler.
package fpadd_pkg;
  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;
  localparam int PKG_ID_W = 2;

  typedef logic [PKG_ID_W-1:0] req_id_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx,
  output logic            found
);
  logic [ID_W-1:0] cand;
  int              pos;

  // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    pos   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      cand = ID_W'(pos);
      if (!found && req[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fpadd_sched.sv
// Round-robin scheduler sharing one start/done fpadd unit among NREQ clients.
// Optional build macro FPADD_TIMEOUT_EN: abort WAIT after TIMEOUT cycles with qNaN and res_err.
module fpadd_sched
  import fpadd_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*FP_W-1:0] a_in,
  input  logic [NREQ*FP_W-1:0] b_in,
  output logic [NREQ-1:0]      gnt,
  output logic                 res_valid,
  output logic [ID_W-1:0]      res_id,
  output logic [FP_W-1:0]      res_sum,
  output logic                 res_err,
  output logic                 busy,
  output logic                 add_start,
  output logic [FP_W-1:0]      add_a,
  output logic [FP_W-1:0]      add_b,
  input  logic [FP_W-1:0]      add_sum,
  input  logic                 add_done
);
  // One counter serves both the settle window and the optional WAIT timeout.
  localparam int CNT_LIM = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int CNT_W   = $clog2(CNT_LIM + 2);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  ptr, cur_id, pick_idx;
  logic [NREQ-1:0]  pick_gnt;
  logic             pick_found;
  logic [CNT_W-1:0] cnt;
  logic             accept, tmo;
  logic [FP_W-1:0]  a_arr [NREQ];
  logic [FP_W-1:0]  b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = a_in[FP_W*i +: FP_W];
    assign b_arr[i] = b_in[FP_W*i +: FP_W];
  end

  rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Gated by reset so no grant is visible while the block is held in reset.
  assign gnt       = (state == IDLE && !reset) ? pick_gnt : '0;
  assign add_start = (state == ISSUE);
  assign res_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      IDLE:  if (pick_found) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        accept = (cnt >= CNT_W'(SETTLE)) && add_done;
`ifdef FPADD_TIMEOUT_EN
        tmo = !accept && (cnt == CNT_W'(TIMEOUT - 1));
`endif
        if (accept || tmo) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FPADD_TIMEOUT_EN
  logic err_q;
  assign res_err = err_q;
`else
  assign res_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= ID_W'(NREQ - 1);
      cur_id  <= '0;
      add_a   <= '0;
      add_b   <= '0;
      res_id  <= '0;
      res_sum <= '0;
      cnt     <= '0;
`ifdef FPADD_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      if (state == IDLE && pick_found) begin
        add_a  <= a_arr[pick_idx];
        add_b  <= b_arr[pick_idx];
        cur_id <= pick_idx;
        ptr    <= pick_idx;
      end
      if (state == ISSUE)
        cnt <= '0;
      else if (state == WAIT && cnt != CNT_W'(CNT_LIM))
        cnt <= cnt + 1'b1;
      if (accept) begin
        res_sum <= add_sum;
        res_id  <= cur_id;
      end else if (tmo) begin
        res_sum <= QNAN;
        res_id  <= cur_id;
      end
`ifdef FPADD_TIMEOUT_EN
      if (accept || tmo) err_q <= tmo;
`endif
    end
  end
endmodule

// File: tb/tb_fpadd_sched.sv
// Directed self-checking bench for fpadd_sched with a fixed-latency table-driven adder model.
module tb_fpadd_sched;
  import fpadd_pkg::*;

  localparam int NREQ = 4;

  typedef struct {
    int          cyc;
    logic [1:0]  id;
    logic [31:0] sum;
    logic        err;
  } res_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*32-1:0] a_in, b_in;
  logic [NREQ-1:0]   gnt;
  logic              res_valid, res_err, busy, add_start, add_done;
  logic [1:0]        res_id;
  logic [31:0]       res_sum, add_a, add_b, add_sum;

  logic ovr = 1'b0, ovr_done = 1'b0, model_done;
  logic m_run;
  int   m_cnt;
  int   cyc = 0, n_start = 0, n_checks = 0, n_errors = 0;
  int   gcount [NREQ];
  res_t res_q [$];

  // r0: 1.0+2.0, r1: 1.5+2.5, r2: 0.5+0.25, r3: 10.0+5.0
  assign a_in = {32'h4120_0000, 32'h3F00_0000, 32'h3FC0_0000, 32'h3F80_0000};
  assign b_in = {32'h40A0_0000, 32'h3E80_0000, 32'h4020_0000, 32'h4000_0000};
  logic [31:0] exp_sum [NREQ] = '{32'h4040_0000, 32'h4080_0000, 32'h3F40_0000, 32'h4170_0000};

  fpadd_sched #(.NREQ(NREQ), .ID_W(2), .SETTLE(2), .TIMEOUT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .res_err   (res_err),
    .busy      (busy),
    .add_start (add_start),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .add_done  (add_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fp_sum(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
      {32'h3FC0_0000, 32'h4020_0000}: return 32'h4080_0000;
      {32'h3F00_0000, 32'h3E80_0000}: return 32'h3F40_0000;
      {32'h4120_0000, 32'h40A0_0000}: return 32'h4170_0000;
      default:                        return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Adder model: done rises 3 cycles after the start pulse and stays up until the next start.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run <= 1'b0;
      m_cnt <= 0;
    end else if (add_start) begin
      m_run <= 1'b1;
      m_cnt <= 1;
    end else if (m_run && m_cnt < 100) begin
      m_cnt <= m_cnt + 1;
    end
  end
  assign model_done = m_run && (m_cnt >= 3);
  assign add_done   = ovr ? ovr_done : model_done;
  assign add_sum    = fp_sum(add_a, add_b);

  always @(posedge clk) cyc <= cyc + 1;

  initial for (int i = 0; i < NREQ; i++) gcount[i] = 0;

  always @(negedge clk) begin
    if (res_valid) res_q.push_back('{cyc, res_id, res_sum, res_err});
    if (add_start) n_start <= n_start + 1;
    for (int i = 0; i < NREQ; i++) if (gnt[i]) gcount[i] <= gcount[i] + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_req(input logic [NREQ-1:0] v);
    @(posedge clk);
    #1 req = v;
  endtask

  task automatic wait_gnt(output logic [NREQ-1:0] g, output int c);
    g = '0;
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g = gnt;
        c = cyc;
        return;
      end
    end
    check("gnt_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_res(input int n, output res_t r);
    r = '{-1, 2'b0, 32'h0, 1'b0};
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (res_q.size() >= n) begin
        r = res_q[n-1];
        return;
      end
    end
    check("res_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] gl [5];
    int   c, c0, s0, nres, g1;
    int   gc [5];
    res_t r;
    bit   seen;

    // Reset state
    #3;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_start", 32'(add_start), 32'h0);
    check("rst_valid", 32'(res_valid), 32'h0);
    check("rst_sum", res_sum, 32'h0);
    check("rst_add_a", add_a, 32'h0);
    do_reset();

    // Single request from requester 0
    s0 = n_start;
    set_req(4'b0001);
    wait_gnt(g, c0);
    check("single_gnt", 32'(g), 32'h1);
    @(posedge clk);
    #1 req = '0;
    @(negedge clk);
    check("single_gnt_pulse", 32'(gnt), 32'h0);
    check("single_start", 32'(add_start), 32'h1);
    wait_res(1, r);
    check("single_id", 32'(r.id), 32'h0);
    check("single_sum", r.sum, 32'h4040_0000);
    check("single_err", 32'(r.err), 32'h0);
    check("single_latency", 32'(r.cyc - c0), 32'd5);
    check("single_nstart", 32'(n_start - s0), 32'd1);
    @(negedge clk);
    check("single_valid_pulse", 32'(res_valid), 32'h0);
    check("single_sum_hold", res_sum, 32'h4040_0000);

    // All four requesting continuously from reset
    req = 4'b1111;
    do_reset();
    nres = res_q.size();
    for (int k = 0; k < 5; k++) begin
      wait_gnt(gl[k], gc[k]);
      if (k == 4) begin
        @(posedge clk);
        #1 req = '0;
      end
    end
    check("rr_g0", 32'(gl[0]), 32'h1);
    check("rr_g1", 32'(gl[1]), 32'h2);
    check("rr_g2", 32'(gl[2]), 32'h4);
    check("rr_g3", 32'(gl[3]), 32'h8);
    check("rr_g4", 32'(gl[4]), 32'h1);
    check("rr_spacing", 32'(gc[1] - gc[0]), 32'd6);
    wait_res(nres + 5, r);
    for (int k = 0; k < 5; k++) begin
      check("rr_res_id", 32'(res_q[nres+k].id), 32'(k % 4));
      check("rr_res_sum", res_q[nres+k].sum, exp_sum[k % 4]);
    end

    // Stale done held through ISSUE and the settle window
    nres = res_q.size();
    s0 = n_start;
    ovr = 1'b1;
    ovr_done = 1'b1;
    set_req(4'b0100);
    wait_gnt(g, c0);
    check("stale_gnt", 32'(g), 32'h4);
    @(posedge clk);
    #1 req = '0;
    repeat (3) @(posedge clk);
    #1 ovr_done = 1'b0;
    repeat (5) @(posedge clk);
    #1 ovr_done = 1'b1;
    wait_res(nres + 1, r);
    check("stale_latency", 32'(r.cyc - c0), 32'd10);
    check("stale_sum", r.sum, 32'h3F40_0000);
    check("stale_nstart", 32'(n_start - s0), 32'd1);
    ovr = 1'b0;

    // Reset during WAIT
    ovr = 1'b1;
    ovr_done = 1'b0;
    set_req(4'b0001);
    wait_gnt(g, c0);
    @(posedge clk);
    #1 req = '0;
    repeat (2) @(posedge clk);
    #2;
    check("wait_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_add_a", add_a, 32'h0);
    check("arst_add_b", add_b, 32'h0);
    check("arst_sum", res_sum, 32'h0);
    check("arst_start", 32'(add_start), 32'h0);
    nres = res_q.size();
    @(posedge clk);
    #1 reset = 1'b0;
    ovr = 1'b0;
    s0 = n_start;
    repeat (10) @(negedge clk);
    #1;
    check("arst_no_start", 32'(n_start - s0), 32'd0);
    check("arst_no_valid", 32'(res_q.size()), 32'(nres));
    set_req(4'b0100);
    wait_gnt(g, c0);
    check("arst_gnt", 32'(g), 32'h4);
    @(posedge clk);
    #1 req = '0;
    wait_res(nres + 1, r);
    check("arst_res_id", 32'(r.id), 32'h2);

    // Requester 1 withdraws just before its turn
    nres = res_q.size();
    set_req(4'b0001);
    wait_gnt(g, c0);
    check("drop_first_gnt", 32'(g), 32'h1);
    @(posedge clk);
    #1 req = 4'b0011;
    g1 = gcount[1];
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("drop_resp_seen", 32'(seen), 32'h1);
    req = 4'b0001;
    wait_gnt(g, c0);
    check("drop_gnt", 32'(g), 32'h1);
    @(posedge clk);
    #1 req = '0;
    wait_res(nres + 2, r);
    check("drop_no_gnt1", 32'(gcount[1] - g1), 32'd0);

    // Adder never answers
    nres = res_q.size();
    ovr = 1'b1;
    ovr_done = 1'b0;
    set_req(4'b1000);
    wait_gnt(g, c0);
    check("tmo_gnt", 32'(g), 32'h8);
    @(posedge clk);
    #1 req = '0;
`ifdef FPADD_TIMEOUT_EN
    wait_res(nres + 1, r);
    check("tmo_latency", 32'(r.cyc - c0), 32'd10);
    check("tmo_sum", r.sum, 32'h7FC0_0000);
    check("tmo_err", 32'(r.err), 32'h1);
    check("tmo_id", 32'(r.id), 32'h3);
`else
    repeat (30) @(negedge clk);
    #1;
    check("hang_busy", 32'(busy), 32'h1);
    check("hang_no_valid", 32'(res_q.size()), 32'(nres));
`endif
    ovr = 1'b0;
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fpadd_sched.md
Name: fpadd_sched

Overview:
- Round-robin scheduler that shares one multi-cycle fpadd unit (start/done handshake, 32-bit IEEE-754 single) among NREQ requesters.
- Captures one requester's operand pair, issues it to the adder, waits for done, and returns the sum tagged with the requester id.
- Sits between the client blocks and the single adder instance.

Parameters:
- NREQ, 4: number of requesters, 2..16.
- ID_W, 2: width of the requester id; must equal clog2(NREQ).
- SETTLE, 2: cycles after add_start during which add_done is ignored, because the adder's done can be stale.
- TIMEOUT, 64: maximum WAIT cycles before abort; only used with FPADD_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  level request per requester
- a_in  in  NREQ*32  operand A, requester i at bits [32i+31:32i]
- b_in  in  NREQ*32  operand B, same packing
- gnt  out  NREQ  one-hot, one-cycle pulse; operands captured this cycle
- res_valid  out  1  one-cycle pulse; result available
- res_id  out  ID_W  requester that owns the result
- res_sum  out  32  result word
- res_err  out  1  timeout abort flag (tied 0 without FPADD_TIMEOUT_EN)
- busy  out  1  high in any state other than IDLE
- add_start  out  1  start pulse to the adder
- add_a  out  32  operand A to the adder, held from ISSUE to end of WAIT
- add_b  out  32  operand B to the adder, same hold
- add_sum  in  32  adder result
- add_done  in  1  adder done level

Behaviour:
- Reset (asynchronous, active-high): state IDLE; gnt, res_valid, res_id, res_sum, res_err, busy, add_start, add_a, add_b all 0; last-grant pointer = NREQ-1, so requester 0 has first priority.
- Reset mid-operation: the in-flight operation is dropped silently and no res_valid is produced. After release, the adder sees no add_start until a new grant.
- FSM states:
  - IDLE: if req != 0, select the first set bit searching from pointer+1 with wrap-around. Latch operands into add_a/add_b, store the id, pulse gnt[id], set pointer = id, go to ISSUE. If req == 0, stay in IDLE.
  - ISSUE: add_start = 1 for exactly one cycle; clear the settle counter; go to WAIT.
  - WAIT: count SETTLE cycles, ignoring add_done. After that, the first cycle with add_done = 1 registers add_sum into res_sum and goes to RESP.
  - RESP: res_valid = 1 for one cycle with res_id and res_sum; go to IDLE.
- Latency: gnt to res_valid = 2 + SETTLE + (adder cycles beyond SETTLE) + 1.
  - Back-to-back throughput is one op per (4 + SETTLE) cycles minimum. The cycle after RESP is IDLE, so there is one arbitration cycle per op.
- req is level-sensitive. The requester holds req and operands stable until its gnt pulse. Dropping req before gnt is legal and the requester is simply skipped. Keeping req high after gnt is treated as a new request.
- Fairness: a requester that keeps req asserted is granted within NREQ grants.
- A req arriving while busy is not registered; it waits in IDLE arbitration.
- res_sum and res_id hold their values after RESP until the next RESP. add_a and add_b hold until the next grant.
- add_done high during ISSUE or the settle window is ignored.
- No backpressure on the result: clients must accept res_valid.

Optional Feature:
- Macro: FPADD_TIMEOUT_EN.
- Defined: a WAIT counter aborts after TIMEOUT cycles without an accepted add_done.
  - RESP then issues with res_sum = 32'h7FC00000 (qNaN) and res_err = 1.
  - res_err is 0 on normal completion.
- Undefined: no counter; WAIT may last indefinitely; res_err is constant 0.

Decomposition:
- Shared package fpadd_pkg:
  - FP_W = 32
  - QNAN = 32'h7FC00000
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - req_id_t typedef, ID_W wide
- One sub-module, rr_pick: a combinational round-robin selector. Inputs req and pointer; outputs a one-hot grant, the index, and a found flag. Also reusable for other shared units.

Test Plan:
- Single request: req = 4'b0001, a_in[0] = 32'h3F800000 (1.0), b_in[0] = 32'h40000000 (2.0), adder model latency 3 → gnt = 0001 one cycle, one add_start pulse, res_valid with res_id = 0 and res_sum = 32'h40400000 (3.0).
- All four requesting continuously from reset → grant order 0, 1, 2, 3, 0; exactly one gnt bit per op; no requester granted twice within any 4 consecutive grants.
- Stale done: adder model holds add_done = 1 throughout ISSUE and the first SETTLE cycles, then drops it and reasserts it 5 cycles later → result accepted only on the later assertion.
- Reset asserted during WAIT → all outputs 0 asynchronously, no res_valid after release; the next req = 4'b0100 is granted requester 2, since the pointer was reset to 3.
- Requester 1 drops req the cycle before its turn with req = 4'b0011, pointer = 0 → requester 0 granted next, no gnt to 1.
- With FPADD_TIMEOUT_EN, TIMEOUT = 8, adder never asserts done → res_valid 8 cycles into WAIT with res_sum = 32'h7FC00000 and res_err = 1. Without the macro → busy stays high, no res_valid.
